// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, FSM state encoding and ROM address layout
// for the per-scanline sprite scheduler.
//   SP_SIZE        sprite width/height in pixels
//   BYTES_PER_ROW  bitmap bytes per sprite row
//   BITMAP_BYTES   bitmap bytes per sprite
//   SCREEN_W/H     visible screen limits
//   sched_state_e  scheduler FSM states
//   mem_addr_f     {sprite index, row, byte} ROM address packing
package sprite_pkg;

    localparam int SP_SIZE       = 32;
    localparam int BYTES_PER_ROW = 4;
    localparam int BITMAP_BYTES  = 128;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Wide index field; callers keep the low clog2(SP_COUNT)+7 bits.
    function automatic logic [15:0] mem_addr_f(input logic [8:0] idx,
                                               input logic [4:0] row,
                                               input logic [1:0] byte_sel);
        mem_addr_f = {idx, row, byte_sel};
    endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// sprite_hit_test: combinational vertical intersection test for one sprite.
// The Y difference wraps at 10 bits, so sprites straddling the top of the
// frame still hit the first lines.
//   next_y_i  line being prepared
//   sp_y_i    sprite top Y
//   sp_en_i   sprite enable
//   hit_o     sprite covers next_y_i
//   row_o     sprite row that lands on next_y_i
module sprite_hit_test
    import sprite_pkg::*;
(
    input  logic [9:0] next_y_i,
    input  logic [9:0] sp_y_i,
    input  logic       sp_en_i,
    output logic       hit_o,
    output logic [4:0] row_o
);

    logic [9:0] diff;

    assign diff  = next_y_i - sp_y_i;
    assign hit_o = sp_en_i && (diff < 10'(SP_SIZE));
    assign row_o = diff[4:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite selection and row prefetch.
// On each line_start_i the previously prepared row set is committed to the
// slot outputs and a new scan/fetch for next_y_i begins.
//   clk_i, rst_n_i       pixel clock, synchronous active-low reset
//   line_start_i         one-cycle pulse at horizontal blank start
//   next_y_i             line to prepare (sampled on line_start_i)
//   sp_x_all_i/sp_y_all_i/sp_en_i  sprite position table and enables
//   mem_rd_o/mem_addr_o/mem_data_i bitmap ROM port (data one cycle after read)
//   slot_valid_o/slot_x_o/slot_id_o/slot_row_o  committed slot set
//   line_ovf_o           committed line had more hits than slots
//   line_late_o          commit arrived before preparation finished
//   busy_o               scan or fetch in progress
// Build option: SPRITE_SCHED_ROTATE_EN rotates the scan start index on every
// line start so overflowed sprites flicker instead of vanishing.
//
// state | meaning
// IDLE  | nothing prepared since reset, waiting for line start
// SCAN  | testing one sprite per cycle in circular priority order
// FETCH | reading 4 row bytes per selected slot, back to back
// DONE  | shadow set complete, held until next line start
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int SP_COUNT = 4,
    parameter int SLOTS    = 2,
    localparam int IW = (SP_COUNT > 1) ? $clog2(SP_COUNT) : 1,
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int CW = $clog2(SLOTS + 1),
    localparam int AW = IW + 7
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   line_start_i,
    input  logic [9:0]             next_y_i,
    input  logic [10*SP_COUNT-1:0] sp_x_all_i,
    input  logic [10*SP_COUNT-1:0] sp_y_all_i,
    input  logic [SP_COUNT-1:0]    sp_en_i,
    output logic                   mem_rd_o,
    output logic [AW-1:0]          mem_addr_o,
    input  logic [7:0]             mem_data_i,
    output logic [SLOTS-1:0]       slot_valid_o,
    output logic [10*SLOTS-1:0]    slot_x_o,
    output logic [IW*SLOTS-1:0]    slot_id_o,
    output logic [32*SLOTS-1:0]    slot_row_o,
    output logic                   line_ovf_o,
    output logic                   line_late_o,
    output logic                   busy_o
);

    sched_state_e        state_q, state_d;
    logic [9:0]          next_y_q, next_y_d;
    logic [IW-1:0]       scan_idx_q, scan_idx_d;
    logic [IW-1:0]       start_q, start_d;
    logic [IW:0]         scan_left_q, scan_left_d;
    logic [CW-1:0]       hit_cnt_q, hit_cnt_d;

    logic [SLOTS-1:0]    sh_valid_q, sh_valid_d;
    logic [10*SLOTS-1:0] sh_x_q, sh_x_d;
    logic [IW*SLOTS-1:0] sh_id_q, sh_id_d;
    logic [5*SLOTS-1:0]  sh_sel_q, sh_sel_d;
    logic [32*SLOTS-1:0] sh_row_q, sh_row_d;
    logic                sh_ovf_q, sh_ovf_d;

    logic [SW-1:0]       f_slot_q, f_slot_d;
    logic [1:0]          f_byte_q, f_byte_d;
    logic                pend_q, pend_d;
    logic [SW-1:0]       pend_slot_q, pend_slot_d;
    logic [1:0]          pend_byte_q, pend_byte_d;

    logic [SLOTS-1:0]    valid_q, valid_d;
    logic [10*SLOTS-1:0] x_q, x_d;
    logic [IW*SLOTS-1:0] id_q, id_d;
    logic [32*SLOTS-1:0] row_q, row_d;
    logic                ovf_q, ovf_d;
    logic                late_q, late_d;

    logic [9:0]          cur_x, cur_y;
    logic                cur_hit;
    logic [4:0]          cur_row;

    always_comb begin
        cur_x = '0;
        cur_y = '0;
        for (int i = 0; i < SP_COUNT; i++) begin
            if (scan_idx_q == IW'(i)) begin
                cur_x = sp_x_all_i[10*i +: 10];
                cur_y = sp_y_all_i[10*i +: 10];
            end
        end
    end

    sprite_hit_test u_hit (
        .next_y_i (next_y_q),
        .sp_y_i   (cur_y),
        .sp_en_i  (sp_en_i[scan_idx_q]),
        .hit_o    (cur_hit),
        .row_o    (cur_row)
    );

    always_comb begin
        state_d     = state_q;
        next_y_d    = next_y_q;
        scan_idx_d  = scan_idx_q;
        start_d     = start_q;
        scan_left_d = scan_left_q;
        hit_cnt_d   = hit_cnt_q;
        sh_valid_d  = sh_valid_q;
        sh_x_d      = sh_x_q;
        sh_id_d     = sh_id_q;
        sh_sel_d    = sh_sel_q;
        sh_row_d    = sh_row_q;
        sh_ovf_d    = sh_ovf_q;
        f_slot_d    = f_slot_q;
        f_byte_d    = f_byte_q;
        pend_d      = 1'b0;
        pend_slot_d = pend_slot_q;
        pend_byte_d = pend_byte_q;
        valid_d     = valid_q;
        x_d         = x_q;
        id_d        = id_q;
        row_d       = row_q;
        ovf_d       = ovf_q;
        late_d      = late_q;
        mem_rd_o    = 1'b0;
        mem_addr_o  = '0;

        // ROM data belongs to the read issued last cycle; byte 0 is leftmost.
        if (pend_q) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int b = 0; b < BYTES_PER_ROW; b++) begin
                    if (pend_slot_q == SW'(s) && pend_byte_q == 2'(b)) begin
                        sh_row_d[32*s + 8*(3-b) +: 8] = mem_data_i;
                    end
                end
            end
        end

        case (state_q)
            ST_SCAN: begin
                if (cur_hit) begin
                    if (hit_cnt_q < CW'(SLOTS)) begin
                        for (int s = 0; s < SLOTS; s++) begin
                            if (hit_cnt_q == CW'(s)) begin
                                sh_valid_d[s]          = 1'b1;
                                sh_x_d[10*s +: 10]     = cur_x;
                                sh_id_d[IW*s +: IW]    = scan_idx_q;
                                sh_sel_d[5*s +: 5]     = cur_row;
                            end
                        end
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        sh_ovf_d = 1'b1;
                    end
                end
                scan_idx_d  = (scan_idx_q == IW'(SP_COUNT-1)) ? '0 : scan_idx_q + 1'b1;
                scan_left_d = scan_left_q - 1'b1;
                f_slot_d    = '0;
                f_byte_d    = '0;
                if (scan_left_q == (IW+1)'(1)) begin
                    state_d = (hit_cnt_d != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                mem_rd_o = 1'b1;
                for (int s = 0; s < SLOTS; s++) begin
                    if (f_slot_q == SW'(s)) begin
                        mem_addr_o = AW'(mem_addr_f(9'(sh_id_q[IW*s +: IW]),
                                                    sh_sel_q[5*s +: 5], f_byte_q));
                    end
                end
                pend_d      = 1'b1;
                pend_slot_d = f_slot_q;
                pend_byte_d = f_byte_q;
                f_byte_d    = f_byte_q + 1'b1;
                if (f_byte_q == 2'(BYTES_PER_ROW-1)) begin
                    f_byte_d = '0;
                    // Last byte of this row lands while already in DONE.
                    if (CW'(f_slot_q) + 1'b1 == hit_cnt_q) begin
                        state_d = ST_DONE;
                    end else begin
                        f_slot_d = f_slot_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        if (line_start_i) begin
            if (state_q == ST_DONE || state_q == ST_IDLE) begin
                valid_d = sh_valid_q;
                x_d     = sh_x_q;
                id_d    = sh_id_q;
                row_d   = sh_row_q;
                ovf_d   = sh_ovf_q;
                late_d  = 1'b0;
            end else begin
                valid_d = '0;
                x_d     = '0;
                id_d    = '0;
                row_d   = '0;
                ovf_d   = 1'b0;
                late_d  = 1'b1;
            end
            state_d     = ST_SCAN;
            next_y_d    = next_y_i;
            scan_idx_d  = start_q;
            scan_left_d = (IW+1)'(SP_COUNT);
`ifdef SPRITE_SCHED_ROTATE_EN
            start_d     = (start_q == IW'(SP_COUNT-1)) ? '0 : start_q + 1'b1;
`else
            start_d     = '0;
`endif
            hit_cnt_d   = '0;
            sh_valid_d  = '0;
            sh_x_d      = '0;
            sh_id_d     = '0;
            sh_sel_d    = '0;
            sh_row_d    = '0;
            sh_ovf_d    = 1'b0;
            f_slot_d    = '0;
            f_byte_d    = '0;
            pend_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            next_y_q    <= '0;
            scan_idx_q  <= '0;
            start_q     <= '0;
            scan_left_q <= '0;
            hit_cnt_q   <= '0;
            sh_valid_q  <= '0;
            sh_x_q      <= '0;
            sh_id_q     <= '0;
            sh_sel_q    <= '0;
            sh_row_q    <= '0;
            sh_ovf_q    <= 1'b0;
            f_slot_q    <= '0;
            f_byte_q    <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            pend_byte_q <= '0;
            valid_q     <= '0;
            x_q         <= '0;
            id_q        <= '0;
            row_q       <= '0;
            ovf_q       <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_y_q    <= next_y_d;
            scan_idx_q  <= scan_idx_d;
            start_q     <= start_d;
            scan_left_q <= scan_left_d;
            hit_cnt_q   <= hit_cnt_d;
            sh_valid_q  <= sh_valid_d;
            sh_x_q      <= sh_x_d;
            sh_id_q     <= sh_id_d;
            sh_sel_q    <= sh_sel_d;
            sh_row_q    <= sh_row_d;
            sh_ovf_q    <= sh_ovf_d;
            f_slot_q    <= f_slot_d;
            f_byte_q    <= f_byte_d;
            pend_q      <= pend_d;
            pend_slot_q <= pend_slot_d;
            pend_byte_q <= pend_byte_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            id_q        <= id_d;
            row_q       <= row_d;
            ovf_q       <= ovf_d;
            late_q      <= late_d;
        end
    end

    assign slot_valid_o = valid_q;
    assign slot_x_o     = x_q;
    assign slot_id_o    = id_q;
    assign slot_row_o   = row_q;
    assign line_ovf_o   = ovf_q;
    assign line_late_o  = late_q;
    assign busy_o       = (state_q == ST_SCAN) || (state_q == ST_FETCH);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a behavioural bitmap ROM.
module tb_sprite_line_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [39:0] sp_x_all = '0;
    logic [39:0] sp_y_all = '0;
    logic [3:0]  sp_en = '0;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data = '0;
    logic [1:0]  slot_valid;
    logic [19:0] slot_x;
    logic [3:0]  slot_id;
    logic [63:0] slot_row;
    logic        line_ovf, line_late, busy;

    logic [9:0]  ht_y = '0, ht_sy = '0;
    logic        ht_en = 1'b0, ht_hit;
    logic [4:0]  ht_row;

    int n_total = 0;
    int n_bad   = 0;
    int lat;
    int cnt;
    logic [8:0] addr_log[$];

    always #5 clk = ~clk;

    sprite_line_scheduler dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .line_start_i (line_start),
        .next_y_i     (next_y),
        .sp_x_all_i   (sp_x_all),
        .sp_y_all_i   (sp_y_all),
        .sp_en_i      (sp_en),
        .mem_rd_o     (mem_rd),
        .mem_addr_o   (mem_addr),
        .mem_data_i   (mem_data),
        .slot_valid_o (slot_valid),
        .slot_x_o     (slot_x),
        .slot_id_o    (slot_id),
        .slot_row_o   (slot_row),
        .line_ovf_o   (line_ovf),
        .line_late_o  (line_late),
        .busy_o       (busy)
    );

    sprite_hit_test u_ref_hit (
        .next_y_i (ht_y),
        .sp_y_i   (ht_sy),
        .sp_en_i  (ht_en),
        .hit_o    (ht_hit),
        .row_o    (ht_row)
    );

    function automatic logic [7:0] rom_f(input logic [8:0] a);
        logic [15:0] t;
        t = {7'd0, a} * 16'd37 + 16'd11;
        return t[7:0];
    endfunction

    function automatic logic [31:0] row4(input logic [8:0] a);
        return {rom_f(a), rom_f(a + 9'd1), rom_f(a + 9'd2), rom_f(a + 9'd3)};
    endfunction

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data <= rom_f(mem_addr);
            addr_log.push_back(mem_addr);
        end
    end

    function automatic logic [35:0] addr_word(input int k);
        if (k + 3 >= addr_log.size()) return '1;
        return {addr_log[k], addr_log[k+1], addr_log[k+2], addr_log[k+3]};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_sp(input int i, input logic [9:0] x, input logic [9:0] y);
        sp_x_all[10*i +: 10] = x;
        sp_y_all[10*i +: 10] = y;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_ls(input logic [9:0] y);
        line_start = 1'b1;
        next_y = y;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle(output int l);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_timeout", 64'(busy), 64'd0);
        l = n + 1;
        @(negedge clk);
    endtask

    task automatic run_line(input logic [9:0] y, output int l);
        addr_log.delete();
        pulse_ls(y);
        wait_idle(l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_val("rst_valid", 64'(slot_valid), 64'd0);
        check_val("rst_memrd", 64'(mem_rd), 64'd0);
        check_val("rst_addr", 64'(mem_addr), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_late_ovf", 64'({line_late, line_ovf}), 64'd0);
        rst_n = 1'b1;

        // single sprite
        for (int i = 0; i < 4; i++) set_sp(i, 10'd0, 10'd300);
        set_sp(0, 10'd50, 10'd60);
        sp_en = 4'b0001;
        run_line(10'd61, lat);
        check_val("t1_lat", 64'(lat), 64'd9);
        check_val("t1_nrd", 64'(addr_log.size()), 64'd4);
        check_val("t1_addrs", 64'(addr_word(0)), 64'({9'h04, 9'h05, 9'h06, 9'h07}));
        run_line(10'd61, lat);
        check_val("t1_valid", 64'(slot_valid), 64'd1);
        check_val("t1_x", 64'(slot_x), 64'd50);
        check_val("t1_id", 64'(slot_id), 64'd0);
        check_val("t1_row", slot_row, {32'd0, row4(9'h04)});
        check_val("t1_ovf_late", 64'({line_ovf, line_late}), 64'd0);

        // no hits
        for (int i = 0; i < 4; i++) set_sp(i, 10'd0, 10'd300);
        sp_en = 4'b1111;
        run_line(10'd10, lat);
        check_val("t2_lat", 64'(lat), 64'd5);
        check_val("t2_nrd", 64'(addr_log.size()), 64'd0);
        run_line(10'd10, lat);
        check_val("t2_valid", 64'(slot_valid), 64'd0);
        check_val("t2_ovf", 64'(line_ovf), 64'd0);
        check_val("t2_row", slot_row, 64'd0);

        // overflow
        do_reset();
        set_sp(0, 10'd10, 10'd100);
        set_sp(1, 10'd20, 10'd100);
        set_sp(2, 10'd30, 10'd100);
        set_sp(3, 10'd40, 10'd300);
        run_line(10'd110, lat);
        check_val("t3_lat", 64'(lat), 64'd13);
        check_val("t3_nrd", 64'(addr_log.size()), 64'd8);
        check_val("t3_addr0", 64'(addr_word(0)), 64'({9'h028, 9'h029, 9'h02A, 9'h02B}));
        check_val("t3_addr1", 64'(addr_word(4)), 64'({9'h0A8, 9'h0A9, 9'h0AA, 9'h0AB}));
        cnt = 0;
        foreach (addr_log[k]) if (addr_log[k][8:7] == 2'd2) cnt++;
        check_val("t3_no_idx2", 64'(cnt), 64'd0);
        run_line(10'd110, lat);
        check_val("t3_valid", 64'(slot_valid), 64'd3);
        check_val("t3_id", 64'(slot_id), 64'(4'b0100));
        check_val("t3_x", 64'(slot_x), 64'({10'd20, 10'd10}));
        check_val("t3_ovf", 64'(line_ovf), 64'd1);
        check_val("t3_row", slot_row, {row4(9'h0A8), row4(9'h028)});
        run_line(10'd110, lat);
`ifdef SPRITE_SCHED_ROTATE_EN
        check_val("t3_rot_id", 64'(slot_id), 64'(4'b1001));
        check_val("t3_rot_x", 64'(slot_x), 64'({10'd30, 10'd20}));
`else
        check_val("t3_fix_id", 64'(slot_id), 64'(4'b0100));
        check_val("t3_fix_x", 64'(slot_x), 64'({10'd20, 10'd10}));
`endif
        check_val("t3_ovf2", 64'(line_ovf), 64'd1);

        // wrap-around
        do_reset();
        for (int i = 0; i < 4; i++) set_sp(i, 10'd0, 10'd300);
        set_sp(0, 10'd5, 10'd1020);
        sp_en = 4'b0001;
        run_line(10'd5, lat);
        check_val("t4_addrs", 64'(addr_word(0)), 64'({9'h024, 9'h025, 9'h026, 9'h027}));
        run_line(10'd28, lat);
        check_val("t4_valid", 64'(slot_valid), 64'd1);
        check_val("t4_row", slot_row, {32'd0, row4(9'h024)});
        check_val("t4_x", 64'(slot_x), 64'd5);
        check_val("t4_lat28", 64'(lat), 64'd5);
        check_val("t4_nrd28", 64'(addr_log.size()), 64'd0);
        run_line(10'd28, lat);
        check_val("t4_valid28", 64'(slot_valid), 64'd0);
        ht_y = 10'd5; ht_sy = 10'd1020; ht_en = 1'b1;
        #1;
        check_val("ht_wrap", 64'({ht_hit, ht_row}), 64'({1'b1, 5'd9}));
        ht_y = 10'd28;
        #1;
        check_val("ht_d32", 64'(ht_hit), 64'd0);
        ht_y = 10'd27;
        #1;
        check_val("ht_d31", 64'({ht_hit, ht_row}), 64'({1'b1, 5'd31}));
        ht_en = 1'b0;
        #1;
        check_val("ht_dis", 64'(ht_hit), 64'd0);
        @(negedge clk);

        // late commit
        do_reset();
        set_sp(0, 10'd10, 10'd100);
        set_sp(1, 10'd20, 10'd100);
        sp_en = 4'b0011;
        pulse_ls(10'd110);
        repeat (5) @(negedge clk);
        check_val("t5_fetching", 64'(mem_rd), 64'd1);
        pulse_ls(10'd110);
        check_val("t5_valid", 64'(slot_valid), 64'd0);
        check_val("t5_late", 64'(line_late), 64'd1);
        check_val("t5_busy", 64'(busy), 64'd1);
        wait_idle(lat);
        run_line(10'd110, lat);
        check_val("t5_valid2", 64'(slot_valid), 64'd3);
        check_val("t5_late2", 64'(line_late), 64'd0);

        // reset mid-fetch, with a line start held during reset
        pulse_ls(10'd110);
        cnt = 0;
        while (!mem_rd && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_val("t6_fetching", 64'(mem_rd), 64'd1);
        rst_n = 1'b0;
        line_start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        line_start = 1'b0;
        check_val("t6_memrd", 64'(mem_rd), 64'd0);
        check_val("t6_busy", 64'(busy), 64'd0);
        check_val("t6_valid", 64'(slot_valid), 64'd0);
        check_val("t6_row", slot_row, 64'd0);
        check_val("t6_xid", 64'({slot_x, slot_id}), 64'd0);
        check_val("t6_flags", 64'({line_ovf, line_late}), 64'd0);
        run_line(10'd110, lat);
        check_val("t6_lat", 64'(lat), 64'd13);
        run_line(10'd110, lat);
        check_val("t6_valid2", 64'(slot_valid), 64'd3);
        check_val("t6_row2", slot_row, {row4(9'h0A8), row4(9'h028)});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
